sort_datapath: RTL and testbench
================================

SORT_DATAPATH -- requirements
Module: sort_datapath

Interface
REQ-001 SHALL provide parameter K, default 8, number of memory entries (K >= 2).
REQ-002 SHALL provide parameter W, default 8, data width in bits.
REQ-003 SHALL provide parameter AW, default 3, counter/address width, equal to clog2(K).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports Li, Ei, Lj, Ej  input  1 each: load/enable counters i and j.
REQ-007 SHALL have ports EA, EB  input  1 each: capture enables for registers A and B.
REQ-008 SHALL have port Wr  input  1  memory write strobe from controller.
REQ-009 SHALL have port Bout  input  1  write-data select: 1 = B, 0 = A.
REQ-010 SHALL have port Csel  input  1  address select: 1 = j, 0 = i.
REQ-011 SHALL have port AgtB  output  1  A > B, unsigned compare.
REQ-012 SHALL have port zi  output  1  i == K-2.
REQ-013 SHALL have port zj  output  1  j == K-1.
REQ-014 SHALL have port host_sel  input  1  host owns memory port.
REQ-015 SHALL have port host_we  input  1  host write strobe.
REQ-016 SHALL have port host_addr  input  AW  host address.
REQ-017 SHALL have port host_wdata  input  W  host write data.
REQ-018 SHALL have port host_rdata  output  W  registered host read data.

Function
REQ-019 SHALL hold K x W memory M with combinational read at the controller address.
REQ-020 SHALL use controller address = Csel ? j : i.
REQ-021 SHALL use controller write data = Bout ? B : A.
REQ-022 SHALL update counter i per edge: Li -> 0; else Ei -> i+1 mod K; else hold. Li has priority over Ei.
REQ-023 SHALL update counter j per edge: Lj -> (i+1) mod K using the pre-edge i; else Ej -> j+1 mod K; else hold. Lj has priority over Ej.
REQ-024 SHALL, when EA=1, set A to M[controller address] as read in the same cycle. EB SHALL do the same for B.
REQ-025 SHALL, when Wr=1 and host_sel=0, write the controller write data to M[controller address] on the edge.
REQ-026 SHALL read the pre-write value when a write and an EA/EB capture hit the same address in one cycle.
REQ-027 SHALL drive AgtB, zi and zj combinationally from the current A, B, i and j, with zero latency.
REQ-028 SHALL, when host_sel=1 and host_we=1, write host_wdata to M[host_addr]. Wr SHALL be ignored while host_sel=1.
REQ-029 SHALL, when host_sel=1, load host_rdata with M[host_addr] every edge (1-cycle latency), and hold it when host_sel=0.
REQ-030 SHALL apply host write and read to the same address in one cycle as read-old-data.
REQ-031 SHALL leave counters and registers A/B controlled only by Li/Ei/Lj/Ej/EA/EB, independent of host_sel.
REQ-032 SHALL ignore host_addr values >= K: no write, and host_rdata = 0.

Reset
REQ-033 SHALL, while rst=1, force i=0, j=0, A=0, B=0, host_rdata=0 and all M entries to 0, asynchronously.
REQ-034 SHALL, after reset, drive AgtB=0, zi=0 (for K>2) and zj=0.
REQ-035 SHALL, when rst is asserted mid-operation, discard any write pending on that edge.

Verification
REQ-036 SHALL cover host load: host_sel=1, write 5,3,7,1,0,2,6,4 to addr 0..7, then read back -> host_rdata matches 1 cycle after each address.
REQ-037 SHALL cover counters: Li+Ei together -> i=0; Ei x6 -> i=6, zi=1; Lj -> j=7, zj=1; Ej -> j=0, zj=0.
REQ-038 SHALL cover capture/compare: M[0]=5, M[1]=3, i=0, j=1; EA (Csel=0) then EB (Csel=1) -> A=5, B=3, AgtB=1.
REQ-039 SHALL cover swap: continuing REQ-038, Wr+Bout (Csel=0) then Wr (Csel=1) -> M[0]=3, M[1]=5.
REQ-040 SHALL cover contention: host_sel=1 with Wr=1 at the same address -> only the host_wdata value is stored.
REQ-041 SHALL cover async reset: rst pulse between clock edges with nonzero state -> all outputs 0 immediately and memory reads 0.

Source files
------------

// File: rtl/sort_datapath.sv
// sort_datapath: index counters, compare registers and a K-entry memory for an in-place sorter,
// with a host port that owns the memory whenever host_sel is high.
module sort_datapath #(
  parameter int K  = 8,
  parameter int W  = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Li,
  input  logic          Ei,
  input  logic          Lj,
  input  logic          Ej,
  input  logic          EA,
  input  logic          EB,
  input  logic          Wr,
  input  logic          Bout,
  input  logic          Csel,
  output logic          AgtB,
  output logic          zi,
  output logic          zj,
  input  logic          host_sel,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [W-1:0]  host_wdata,
  output logic [W-1:0]  host_rdata
);
  logic [AW-1:0] i, j, addr;
  logic [W-1:0]  a, b, rd, wd;
  logic [W-1:0]  mem [K];
  logic          host_ok;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] v);
    return (v == AW'(K-1)) ? '0 : v + AW'(1);
  endfunction
  assign addr    = Csel ? j : i;
  assign rd      = mem[addr];
  assign wd      = Bout ? b : a;
  assign host_ok = {1'b0, host_addr} < (AW+1)'(K);
  assign AgtB    = a > b;
  assign zi      = i == AW'(K-2);
  assign zj      = j == AW'(K-1);
  // Host access takes priority over the controller write; reads see pre-edge contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i          <= '0;
      j          <= '0;
      a          <= '0;
      b          <= '0;
      host_rdata <= '0;
      for (int n = 0; n < K; n++) mem[n] <= '0;
    end else begin
      i <= Li ? '0 : Ei ? inc(i) : i;
      j <= Lj ? inc(i) : Ej ? inc(j) : j;
      if (EA) a <= rd;
      if (EB) b <= rd;
      if (host_sel) host_rdata <= host_ok ? mem[host_addr] : '0;
      if (host_sel && host_we && host_ok) mem[host_addr] <= host_wdata;
      else if (!host_sel && Wr) mem[addr] <= wd;
    end
  end
endmodule

// File: tb/tb_sort_datapath.sv
// tb_sort_datapath: directed scenarios plus random traffic checked against a behavioural model.
module tb_sort_datapath;
  localparam int K = 8, W = 8, AW = 3;
  logic clk = 0, rst = 1;
  logic Li, Ei, Lj, Ej, EA, EB, Wr, Bout, Csel, host_sel, host_we;
  logic AgtB, zi, zj;
  logic [AW-1:0] host_addr;
  logic [W-1:0] host_wdata, host_rdata;
  int n_cmp = 0, n_fail = 0;
  int mi, mj;
  logic [W-1:0] ma, mb, mhr;
  logic [W-1:0] mm [K];
  logic [W-1:0] vals [K] = '{5, 3, 7, 1, 0, 2, 6, 4};

  sort_datapath #(.K(K), .W(W), .AW(AW)) dut (
    .clk(clk), .rst(rst), .Li(Li), .Ei(Ei), .Lj(Lj), .Ej(Ej), .EA(EA), .EB(EB),
    .Wr(Wr), .Bout(Bout), .Csel(Csel), .AgtB(AgtB), .zi(zi), .zj(zj),
    .host_sel(host_sel), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mi = 0; mj = 0; ma = 0; mb = 0; mhr = 0;
    for (int k = 0; k < K; k++) mm[k] = 0;
  endtask

  task automatic check_all();
    chk("i", 32'(dut.i), 32'(mi));
    chk("j", 32'(dut.j), 32'(mj));
    chk("AgtB", 32'(AgtB), 32'(ma > mb));
    chk("zi", 32'(zi), 32'(mi == K - 2));
    chk("zj", 32'(zj), 32'(mj == K - 1));
    chk("host_rdata", 32'(host_rdata), 32'(mhr));
  endtask

  task automatic idle();
    {Li, Ei, Lj, Ej, EA, EB, Wr, Bout, Csel, host_sel, host_we} = '0;
    host_addr = 0; host_wdata = 0;
  endtask

  // One clock: predict the next state from the current inputs, clock, then compare.
  task automatic cyc();
    int addr, ni, nj;
    logic [W-1:0] rdv, wdv, na, nb, nhr;
    addr = Csel ? mj : mi;
    rdv = mm[addr];
    wdv = Bout ? mb : ma;
    ni = Li ? 0 : Ei ? (mi + 1) % K : mi;
    nj = Lj ? (mi + 1) % K : Ej ? (mj + 1) % K : mj;
    na = EA ? rdv : ma;
    nb = EB ? rdv : mb;
    nhr = host_sel ? ((int'(host_addr) < K) ? mm[host_addr] : 0) : mhr;
    @(posedge clk);
    if (host_sel) begin
      if (host_we && int'(host_addr) < K) mm[host_addr] = host_wdata;
    end else if (Wr) mm[addr] = wdv;
    mi = ni; mj = nj; ma = na; mb = nb; mhr = nhr;
    #1;
    check_all();
  endtask

  task automatic host_read(input int ad, input logic [W-1:0] exp, input string tag);
    idle(); host_sel = 1; host_addr = AW'(ad);
    cyc();
    chk(tag, 32'(host_rdata), 32'(exp));
  endtask

  initial begin
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 0;
    #1;
    check_all();
    chk("reset_A", 32'(dut.a), 0);
    chk("reset_B", 32'(dut.b), 0);

    // Host load then read-back
    for (int k = 0; k < K; k++) begin
      idle(); host_sel = 1; host_we = 1; host_addr = AW'(k); host_wdata = vals[k];
      cyc();
    end
    for (int k = 0; k < K; k++) host_read(k, vals[k], "host_load_rd");

    // Counters
    idle(); Li = 1; Ei = 1; cyc(); chk("i_li_ei", 32'(dut.i), 0);
    idle(); Ei = 1; repeat (6) cyc();
    chk("i_after6", 32'(dut.i), 6); chk("zi_at6", 32'(zi), 1);
    idle(); Lj = 1; cyc(); chk("j_lj", 32'(dut.j), 7); chk("zj_at7", 32'(zj), 1);
    idle(); Ej = 1; cyc(); chk("j_wrap", 32'(dut.j), 0); chk("zj_wrap", 32'(zj), 0);

    // Capture/compare with i=0, j=1
    idle(); Li = 1; cyc();
    idle(); Lj = 1; cyc();
    chk("i0", 32'(dut.i), 0); chk("j1", 32'(dut.j), 1);
    idle(); EA = 1; cyc();
    idle(); EB = 1; Csel = 1; cyc();
    chk("A_cap", 32'(dut.a), 5); chk("B_cap", 32'(dut.b), 3); chk("AgtB_cap", 32'(AgtB), 1);

    // Swap
    idle(); Wr = 1; Bout = 1; cyc();
    idle(); Wr = 1; Csel = 1; cyc();
    host_read(0, 3, "swap_m0");
    host_read(1, 5, "swap_m1");

    // Contention: host write wins over controller write at same address
    idle(); host_sel = 1; host_we = 1; host_addr = 0; host_wdata = 8'hAA; Wr = 1; cyc();
    host_read(0, 8'hAA, "contention_m0");

    // Same-cycle host write/read returns old data
    idle(); host_sel = 1; host_we = 1; host_addr = 3; host_wdata = 8'h3C; cyc();
    chk("rd_old", 32'(host_rdata), 32'(vals[3]));
    host_read(3, 8'h3C, "rd_new");

    // Random traffic
    for (int t = 0; t < 400; t++) begin
      {Li, Ei, Lj, Ej, EA, EB, Wr, Bout, Csel, host_sel, host_we} = 11'($urandom);
      Li = Li & ($urandom_range(0, 3) == 0);
      Lj = Lj & ($urandom_range(0, 3) == 0);
      host_addr = AW'($urandom);
      host_wdata = W'($urandom);
      cyc();
    end
    for (int k = 0; k < K; k++) host_read(k, mm[k], "rand_mem");

    // Make state nonzero, then asynchronous reset pulse between edges
    idle(); Ei = 1; Ej = 1; EA = 1; host_sel = 1; host_addr = 0; cyc();
    @(negedge clk); #2 rst = 1; #1;
    model_reset();
    check_all();
    chk("async_A", 32'(dut.a), 0);
    chk("async_B", 32'(dut.b), 0);
    chk("async_hr", 32'(host_rdata), 0);

    // Reset held across an edge with a pending write: write discarded
    idle(); Wr = 1; Ei = 1; EA = 1;
    @(posedge clk); #1;
    check_all();
    @(negedge clk); rst = 0; idle();
    for (int k = 0; k < K; k++) host_read(k, 0, "post_rst_mem");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
